// File: rtl/aes_pkg.sv
// Shared definitions for the AES command front end: host command codes,
// FSM state encoding and the AES block width.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    C_ID = 2'b00,
    C_SP = 2'b01,
    C_SK = 2'b10,
    C_ST = 2'b11
  } cmd_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/aes_byte_loader.sv
// Byte-serial operand loader: shifts bytes in MSB-first, counts the current
// run modulo BYTES and flags when a full run of BYTES bytes has been captured.
module aes_byte_loader
  import aes_pkg::*;
#(
  parameter int BYTES = AES_BLOCK_W / 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               load_en,
  input  logic               consume,
  input  logic [7:0]         din,
  output logic [8*BYTES-1:0] data,
  output logic               full
);

  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [8*BYTES-1:0] data_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   idx;
  logic               full_reg;
  logic               in_run_reg;

  // A load that does not directly follow another load starts a fresh run at byte 0.
  assign idx = in_run_reg ? cnt_reg : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_reg   <= '0;
      cnt_reg    <= '0;
      full_reg   <= 1'b0;
      in_run_reg <= 1'b0;
    end else begin
      in_run_reg <= load_en;
      if (load_en) begin
        data_reg <= {data_reg[8*BYTES-9:0], din};
        cnt_reg  <= (idx == LAST) ? '0 : idx + 1'b1;
        full_reg <= (idx == LAST) | (in_run_reg & full_reg);
      end else if (consume) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign data = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/aes_input_interface.sv
// Host command front end of the AES engine: assembles plaintext and key,
// launches the round core once per host start and holds operands while busy.
module aes_input_interface
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = AES_BLOCK_W / 8,
  parameter int KEY_BYTES   = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [7:0]               din,
  input  logic [1:0]               cmd,
  output logic                     interface_ready,
  output logic [8*BLOCK_BYTES-1:0] plaintext,
  output logic [8*KEY_BYTES-1:0]   key,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     cmd_err
);

  state_e state_reg;
  logic   ready_reg;
  logic   core_start_reg;
  logic   cmd_err_reg;
  logic   st_prev_reg;

  logic accept;
  logic pt_load;
  logic key_load;
  logic st_edge;
  logic start_ok;
  logic start_bad;
  logic pt_full;
  logic key_full;

  // ready_reg is low for the first cycle after reset, so it also gates acceptance.
  assign accept    = (state_reg == S_IDLE) && ready_reg;
  assign pt_load   = accept && (cmd == C_SP);
  assign key_load  = accept && (cmd == C_SK);
  assign st_edge   = accept && (cmd == C_ST) && !st_prev_reg;
  assign start_ok  = st_edge && pt_full && key_full;
  assign start_bad = st_edge && !(pt_full && key_full);

  aes_byte_loader #(
    .BYTES(BLOCK_BYTES)
  ) u_pt_loader (
    .clk     (clk),
    .rst_    (rst_),
    .load_en (pt_load),
    .consume (start_ok),
    .din     (din),
    .data    (plaintext),
    .full    (pt_full)
  );

  // The key survives a start so consecutive blocks only need new plaintext.
  aes_byte_loader #(
    .BYTES(KEY_BYTES)
  ) u_key_loader (
    .clk     (clk),
    .rst_    (rst_),
    .load_en (key_load),
    .consume (1'b0),
    .din     (din),
    .data    (key),
    .full    (key_full)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg      <= S_IDLE;
      ready_reg      <= 1'b0;
      core_start_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
      st_prev_reg    <= 1'b0;
    end else begin
      st_prev_reg    <= (cmd == C_ST);
      core_start_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          ready_reg <= 1'b1;
          if (start_ok) begin
            state_reg      <= S_BUSY;
            ready_reg      <= 1'b0;
            core_start_reg <= 1'b1;
          end else if (start_bad) begin
            cmd_err_reg <= 1'b1;
          end
        end
        S_BUSY: begin
          if (core_done) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign interface_ready = ready_reg;
  assign core_start      = core_start_reg;
  assign cmd_err         = cmd_err_reg;

endmodule

// File: tb/tb_aes_input_interface.sv
// Self-checking bench for aes_input_interface: directed scenarios plus a
// randomized command stream compared against a run-length behavioural model.
module tb_aes_input_interface;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic [7:0]   din = 8'h00;
  logic [1:0]   cmd = 2'b00;
  logic         core_done = 1'b0;
  logic         interface_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         core_start;
  logic         cmd_err;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] PT1  = 128'h00041214120412000C00131108231919;
  localparam logic [127:0] KEY1 = 128'h2475A2B33475568831E2120013AA5487;
  localparam logic [127:0] PT5  = 128'h05060708090A0B0C0D0E0F1011121314;

  // Behavioural model: run lengths instead of counters, plain shift arithmetic.
  bit           m_busy, m_ready, m_start, m_err, m_prev11;
  bit           m_pt_full, m_key_full;
  int           m_pt_run, m_key_run;
  logic [1:0]   m_prev_load;
  logic [127:0] m_pt, m_key;

  aes_input_interface dut (
    .clk             (clk),
    .rst_            (rst_),
    .din             (din),
    .cmd             (cmd),
    .interface_ready (interface_ready),
    .plaintext       (plaintext),
    .key             (key),
    .core_start      (core_start),
    .core_done       (core_done),
    .cmd_err         (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_start = 0; m_err = 0; m_prev11 = 0;
    m_pt_full = 0; m_key_full = 0; m_pt_run = 0; m_key_run = 0;
    m_prev_load = 2'b00; m_pt = '0; m_key = '0;
  endtask

  // Drives one cycle, advances the model, returns 1ns after the edge.
  task automatic drive_cycle(input logic [1:0] c, input logic [7:0] d, input logic done);
    bit acc;
    cmd = c; din = d; core_done = done;
    @(posedge clk);
    acc = !m_busy && m_ready;
    m_start = 0; m_err = 0;
    if (acc) begin
      if (c == 2'b01) begin
        if (m_prev_load != 2'b01) begin m_pt_run = 0; m_pt_full = 0; end
        m_pt = (m_pt << 8) | 128'(d);
        m_pt_run++;
        if (m_pt_run >= 16) m_pt_full = 1;
      end else if (c == 2'b10) begin
        if (m_prev_load != 2'b10) begin m_key_run = 0; m_key_full = 0; end
        m_key = (m_key << 8) | 128'(d);
        m_key_run++;
        if (m_key_run >= 16) m_key_full = 1;
      end else if (c == 2'b11 && !m_prev11) begin
        if (m_pt_full && m_key_full) begin
          m_start = 1; m_busy = 1; m_pt_full = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_busy && done) begin
      m_busy = 0;
    end
    m_prev_load = (acc && (c == 2'b01 || c == 2'b10)) ? c : 2'b00;
    m_ready = !m_busy;
    m_prev11 = (c == 2'b11);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 0; cmd = 2'b00; din = 8'h00; core_done = 0;
    model_reset();
    @(posedge clk); #1;
    total++;
    if ({interface_ready, core_start, cmd_err, plaintext, key} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b st=%b err=%b pt=%h key=%h, want all 0",
               interface_ready, core_start, cmd_err, plaintext, key);
    end
    @(negedge clk); rst_ = 1;
    drive_cycle(2'b00, 8'h00, 0);
    total++;
    if (interface_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_rise: got %b want 1", interface_ready);
    end
    $display("test_reset: done");
  endtask

  task automatic test_load_and_start();
    logic [7:0] pb [16] = '{8'h00,8'h04,8'h12,8'h14,8'h12,8'h04,8'h12,8'h00,
                            8'h0C,8'h00,8'h13,8'h11,8'h08,8'h23,8'h19,8'h19};
    logic [7:0] kb [16] = '{8'h24,8'h75,8'hA2,8'hB3,8'h34,8'h75,8'h56,8'h88,
                            8'h31,8'hE2,8'h12,8'h00,8'h13,8'hAA,8'h54,8'h87};
    int starts = 0;
    for (int i = 0; i < 16; i++) drive_cycle(2'b01, pb[i], 0);
    total++;
    if (plaintext !== PT1 || plaintext !== m_pt) begin
      bad++;
      $display("FAIL pt_load: got %h want %h", plaintext, PT1);
    end
    for (int i = 0; i < 16; i++) drive_cycle(2'b10, kb[i], 0);
    total++;
    if (key !== KEY1 || key !== m_key) begin
      bad++;
      $display("FAIL key_load: got %h want %h", key, KEY1);
    end
    drive_cycle(2'b11, 8'h00, 0);
    total++;
    if (core_start !== 1'b1 || interface_ready !== 1'b0 || core_start !== m_start) begin
      bad++;
      $display("FAIL start_latency: got start=%b rdy=%b want start=1 rdy=0", core_start, interface_ready);
    end
    if (core_start) starts++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b11, 8'hFF, 0);
      if (core_start) starts++;
      total++;
      if (interface_ready !== 1'b0 || plaintext !== PT1) begin
        bad++;
        $display("FAIL busy_hold: got rdy=%b pt=%h want rdy=0 pt=%h", interface_ready, plaintext, PT1);
      end
    end
    drive_cycle(2'b11, 8'h00, 1);
    total++;
    if (interface_ready !== 1'b1) begin
      bad++;
      $display("FAIL done_ready: got %b want 1", interface_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b11, 8'h00, 0);
      if (core_start) starts++;
    end
    total++;
    if (starts != 1 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL single_start: got starts=%0d err=%b want starts=1 err=0", starts, cmd_err);
    end
    drive_cycle(2'b00, 8'h00, 0);
    $display("test_load_and_start: starts=%0d", starts);
  endtask

  task automatic test_early_start();
    for (int i = 0; i < 10; i++) drive_cycle(2'b01, 8'(i + 8'h40), 0);
    drive_cycle(2'b11, 8'h00, 0);
    total++;
    if (cmd_err !== 1'b1 || core_start !== 1'b0 || interface_ready !== 1'b1) begin
      bad++;
      $display("FAIL early_start: got err=%b st=%b rdy=%b want 1 0 1", cmd_err, core_start, interface_ready);
    end
    drive_cycle(2'b00, 8'h00, 0);
    total++;
    if (cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse_width: got %b want 0", cmd_err);
    end
    $display("test_early_start: done");
  endtask

  task automatic test_plaintext_only();
    logic [127:0] exp_pt = '0;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_pt = (exp_pt << 8) | 128'(b);
      drive_cycle(2'b01, b, 0);
    end
    drive_cycle(2'b11, 8'h00, 0);
    total++;
    if (core_start !== 1'b1 || key !== KEY1 || plaintext !== exp_pt) begin
      bad++;
      $display("FAIL pt_only_start: got st=%b key=%h pt=%h want st=1 key=%h pt=%h",
               core_start, key, plaintext, KEY1, exp_pt);
    end
    drive_cycle(2'b00, 8'h00, 0);
    drive_cycle(2'b00, 8'h00, 1);
    total++;
    if (interface_ready !== 1'b1) begin
      bad++;
      $display("FAIL pt_only_done: got %b want 1", interface_ready);
    end
    $display("test_plaintext_only: pt=%h", exp_pt);
  endtask

  task automatic test_overwrite_restart();
    for (int i = 1; i <= 20; i++) drive_cycle(2'b01, 8'(i), 0);
    total++;
    if (plaintext !== PT5) begin
      bad++;
      $display("FAIL pt_overwrite: got %h want %h", plaintext, PT5);
    end
    drive_cycle(2'b00, 8'h00, 0);
    for (int i = 0; i < 15; i++) drive_cycle(2'b01, 8'(8'h80 + i), 0);
    drive_cycle(2'b11, 8'h00, 0);
    total++;
    if (cmd_err !== 1'b1 || core_start !== 1'b0) begin
      bad++;
      $display("FAIL run_restart: got err=%b st=%b want 1 0", cmd_err, core_start);
    end
    drive_cycle(2'b00, 8'h00, 0);
    for (int i = 0; i < 16; i++) drive_cycle(2'b01, 8'(8'hA0 + i), 0);
    drive_cycle(2'b11, 8'h00, 0);
    total++;
    if (core_start !== 1'b1 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL full_after_restart: got st=%b err=%b want 1 0", core_start, cmd_err);
    end
    drive_cycle(2'b00, 8'h00, 1);
    $display("test_overwrite_restart: done");
  endtask

  task automatic test_random();
    logic [1:0] c;
    int len;
    int cyc = 0;
    while (cyc < 1500) begin
      c = 2'($urandom_range(0, 3));
      len = (c == 2'b11) ? $urandom_range(1, 3) : $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        drive_cycle(c, 8'($urandom), ($urandom_range(0, 7) == 0));
        cyc++;
        total++;
        if ({interface_ready, core_start, cmd_err, plaintext, key} !==
            {m_ready, m_start, m_err, m_pt, m_key}) begin
          bad++;
          $display("FAIL random_cycle%0d: got rdy=%b st=%b err=%b pt=%h key=%h want rdy=%b st=%b err=%b pt=%h key=%h",
                   cyc, interface_ready, core_start, cmd_err, plaintext, key,
                   m_ready, m_start, m_err, m_pt, m_key);
        end
        if (m_start) $display("random: start cycle=%0d pt=%h", cyc, m_pt);
        if (m_err)   $display("random: cmd_err cycle=%0d", cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    while (m_busy) drive_cycle(2'b00, 8'h00, 1);
    drive_cycle(2'b00, 8'h00, 0);
    for (int i = 0; i < 16; i++) drive_cycle(2'b10, 8'(8'h30 + i), 0);
    for (int i = 0; i < 16; i++) drive_cycle(2'b01, 8'(8'h50 + i), 0);
    drive_cycle(2'b11, 8'h00, 0);
    drive_cycle(2'b11, 8'h00, 0);
    rst_ = 0; model_reset(); #1;
    total++;
    if ({interface_ready, core_start, cmd_err, plaintext, key} !== '0) begin
      bad++;
      $display("FAIL async_reset_busy: got rdy=%b st=%b err=%b pt=%h key=%h want all 0",
               interface_ready, core_start, cmd_err, plaintext, key);
    end
    @(negedge clk); rst_ = 1;
    drive_cycle(2'b00, 8'h00, 1);
    for (int i = 0; i < 7; i++) drive_cycle(2'b10, 8'(8'hC0 + i), 0);
    rst_ = 0; model_reset(); #1;
    total++;
    if ({interface_ready, core_start, cmd_err, plaintext, key} !== '0) begin
      bad++;
      $display("FAIL async_reset_keyload: got rdy=%b st=%b err=%b pt=%h key=%h want all 0",
               interface_ready, core_start, cmd_err, plaintext, key);
    end
    @(negedge clk); rst_ = 1;
    drive_cycle(2'b00, 8'h00, 0);
    total++;
    if (core_start !== 1'b0 || cmd_err !== 1'b0 || interface_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_quiet: got st=%b err=%b rdy=%b want 0 0 1", core_start, cmd_err, interface_ready);
    end
    begin
      logic [7:0] pb [16] = '{8'h00,8'h04,8'h12,8'h14,8'h12,8'h04,8'h12,8'h00,
                              8'h0C,8'h00,8'h13,8'h11,8'h08,8'h23,8'h19,8'h19};
      for (int i = 0; i < 16; i++) drive_cycle(2'b01, pb[i], 0);
    end
    total++;
    if (plaintext !== PT1 || key !== 128'h0) begin
      bad++;
      $display("FAIL post_reset_load: got pt=%h key=%h want pt=%h key=0", plaintext, key, PT1);
    end
    drive_cycle(2'b11, 8'h00, 0);
    total++;
    if (cmd_err !== 1'b1 || core_start !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_no_key: got err=%b st=%b want 1 0", cmd_err, core_start);
    end
    $display("test_reset_mid: done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_and_start();
    test_early_start();
    test_plaintext_only();
    test_overwrite_restart();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_input_interface.md
Name: aes_input_interface

Overview:
Byte-serial command front end of aes_engine, sitting directly upstream of the AES round core. Accepts the 2-bit cmd plus 8-bit din stream and assembles the 128-bit plaintext and key, one byte per clock. Issues a one-cycle start pulse to the core and holds the operands stable until the core reports completion. Drives interface_ready toward the host.

Parameters:
BLOCK_BYTES, 16, bytes per plaintext block; sets plaintext width to 8*BLOCK_BYTES.
KEY_BYTES, 16, bytes per key; sets key width to 8*KEY_BYTES. Only 16 (AES-128) is supported for now.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_  in  1  reset, asynchronous, active-low.
din  in  8  host data byte, sampled on the rising edge.
cmd  in  2  host command: 00 idle, 01 set plaintext, 10 set key, 11 start.
interface_ready  out  1  high when host commands are accepted.
plaintext  out  8*BLOCK_BYTES  assembled block; first byte received lands in [127:120].
key  out  8*KEY_BYTES  assembled key; first byte received lands in [127:120].
core_start  out  1  one-cycle pulse that launches the core.
core_done  in  1  one-cycle pulse from the core when the ciphertext is handed to the output interface.
cmd_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - plaintext, key, counters, pt_full, key_full, core_start and cmd_err all go to 0.
  - interface_ready goes to 0 and rises on the first rising edge after rst_ deasserts.
  - Reset asserted mid-load or mid-encryption aborts all activity with no start and no error pulse.
- States: IDLE (ready=1) and BUSY (ready=0).
- Plaintext load (IDLE, cmd=01):
  - Each edge does plaintext <= {plaintext[119:0], din} and pt_cnt increments modulo 16.
  - The first 01 cycle after any other cmd forces pt_cnt to restart at 0 and clears pt_full. That byte counts as byte 0.
  - pt_full sets on the edge that captures the 16th consecutive byte.
  - Further consecutive bytes keep shifting with pt_full held at 1, so the register holds the most recent 16 bytes.
- Key load (IDLE, cmd=10): identical rules using key, key_cnt and key_full. A direct 01→10 switch with no idle cycle is legal.
- Start (IDLE, cmd=11):
  - If pt_full and key_full are both set: core_start=1 on the next cycle, the state goes to BUSY and ready drops in that same cycle.
  - Start latency is 1 clock from the sampling edge.
  - pt_full clears on start because the plaintext is consumed.
  - key_full is retained, so the next block needs plaintext only.
  - If either flag is clear: cmd_err pulses for 1 cycle, the state stays IDLE and nothing else changes.
- BUSY:
  - All cmd/din are ignored, including a held cmd=11; plaintext and key are frozen.
  - On core_done the state returns to IDLE and ready=1 on the next cycle.
  - A cmd=11 still held at that point is treated as a new command only after one intervening non-11 cycle. This guarantees one start per host start assertion (edge-detect on cmd==11).
- core_done while IDLE: ignored.
- cmd=00: no state change; it breaks the current load run.

Decomposition:
- Shared package aes_pkg:
  - cmd encodings C_ID=2'b00, C_SP=2'b01, C_SK=2'b10, C_ST=2'b11.
  - IDLE/BUSY state encoding.
  - AES_BLOCK_W=128.
- One sub-module aes_byte_loader (shift register, mod-16 counter, full flag, run-restart detect), instantiated once for plaintext and once for key.
- The top-level FSM, start edge-detect and error pulse live in aes_input_interface.

Test Plan:
1. Reset, then 16 cycles of cmd=01 with bytes 00 04 12 14 12 04 12 00 0C 00 13 11 08 23 19 19 → plaintext=128'h00041214120412000C00131108231919, pt_full=1 after 16th edge.
2. Immediately cmd=10 with bytes 24 75 A2 B3 34 75 56 88 31 E2 12 00 13 AA 54 87, then cmd=11 held → key=128'h2475A2B33475568831E2120013AA5487; core_start high exactly 1 cycle, 1 clock after the first 11 edge; ready=0 until core_done; then ready=1 and no second start while 11 remains held.
3. cmd=11 after only 10 plaintext bytes → cmd_err single pulse, no core_start, ready stays 1.
4. After scenario 2 completes, load a new 16-byte plaintext only, then cmd=11 → start accepted with the key unchanged.
5. 20 consecutive cmd=01 bytes 01..14 (hex) → plaintext = bytes 05..14, pt_full=1; a 01 run broken by a 00 and resumed restarts the count (pt_full=0 until 16 new bytes).
6. Assert rst_ mid-BUSY and mid-key-load → all outputs 0 immediately (async), no start or error; normal scenario 1 passes afterwards.
